text_cursor_controller: RTL
===========================

TEXT_CURSOR_CONTROLLER -- requirements
Module: text_cursor_controller

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset, with ports as listed below.
REQ-002 Parameter COLS, default 60: characters per row (480 px / 8 px glyph).
REQ-003 Parameter ROWS, default 17: character rows (272 px / 16 px glyph).
REQ-004 Parameter DEBOUNCE_CYCLES, default 90000: stable-input cycles before a button level is accepted (10 ms at 9 MHz).
REQ-005 Ports SHALL be as follows.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  function enable; 0 freezes all state.
- btn  in  3  raw asynchronous buttons, active-high: [0] write, [1] backspace, [2] clear.
- sw  in  7  ASCII code to write.
- wr_valid  out  1  character-RAM write request.
- wr_ready  in  1  character-RAM port grant.
- wr_addr  out  10  cell address, row*COLS+col.
- wr_data  out  7  character code.
- cursor_col  out  6  current column.
- cursor_row  out  5  current row.
- busy  out  1  state is not IDLE.

Function
REQ-006 Each btn bit SHALL pass through a 2-flop synchronizer and then a debouncer. The debounced level changes only after the synchronized input has held the new value for DEBOUNCE_CYCLES consecutive cycles.
REQ-007 A press event SHALL be a 0->1 transition of the debounced level, lasting one cycle.
REQ-008 The FSM SHALL have the states IDLE, WRITE, BKSP and CLEAR.
REQ-009 In IDLE, press events SHALL be decoded with priority clear > backspace > write. Lower-priority events in the same cycle are dropped.
REQ-010 Press events arriving in any state other than IDLE SHALL be dropped, not queued.
REQ-011 A write press SHALL produce the following sequence.
- Next cycle: wr_valid=1, wr_addr=cursor address, wr_data=sw. sw is sampled in the press-event cycle.
- Then: enter WRITE.
REQ-012 A backspace press SHALL produce the following sequence.
- Next cycle: cursor steps back one cell.
- Same cycle: wr_valid=1, wr_data=7'h20, wr_addr=new cursor address.
- Then: enter BKSP.
REQ-013 A clear press SHALL produce the following sequence.
- Next cycle: enter CLEAR with wr_addr=0, wr_data=7'h20, wr_valid=1.
REQ-014 A transfer SHALL occur in a cycle where wr_valid=1 and wr_ready=1. wr_addr and wr_data SHALL stay stable while wr_valid=1 and wr_ready=0.
REQ-015 After a WRITE transfer, the cursor SHALL advance, wr_valid SHALL go to 0 on the next cycle, and the FSM SHALL return to IDLE. Cursor advance rules:
- col < COLS-1: col+1.
- Otherwise: col=0, row+1.
- At (ROWS-1, COLS-1): wrap to (0,0).
REQ-016 After a BKSP transfer, the FSM SHALL return to IDLE with the cursor unchanged.
REQ-017 Backspace step-back rules:
- From col 0: go to col COLS-1 of the previous row.
- From (0,0): stay at (0,0) and still write a space to address 0.
REQ-018 In CLEAR, each transfer SHALL increment wr_addr. After the transfer at address COLS*ROWS-1 the block SHALL:
- deassert wr_valid on the next cycle;
- set the cursor to (0,0);
- return to IDLE.
A full clear therefore makes exactly COLS*ROWS transfers.
REQ-019 While en=0, the block SHALL behave as follows.
- wr_valid forced to 0; no transfer can occur.
- FSM, cursor and address held.
- Press events dropped; debouncers keep running.
- On return to en=1, the operation in progress resumes.
REQ-020 All address arithmetic SHALL be performed at 10 bits. COLS*ROWS SHALL NOT exceed 1024, checked at elaboration.
REQ-021 busy SHALL be 1 in WRITE, BKSP and CLEAR, and 0 in IDLE.

Reset
REQ-022 On reset, the block SHALL set the following.
- state=IDLE.
- cursor=(0,0).
- wr_valid=0, wr_addr=0, wr_data=0, busy=0.
- Synchronizers, debounced levels and debounce counters all at 0.
REQ-023 A reset during WRITE, BKSP or CLEAR SHALL abort the operation with no further transfers. A partially cleared screen is acceptable.

Structure
REQ-024 The package char_disp_pkg SHALL hold:
- COLS, ROWS and CELLS=COLS*ROWS;
- the SPACE code 7'h20;
- the FSM state encoding;
- the button index constants.
REQ-025 A sub-module btn_debounce (synchronizer, counter and rising-edge pulse) SHALL be instantiated three times.

Verification
REQ-026 The bench SHALL run with DEBOUNCE_CYCLES=4 and wr_ready tied to 1, and cover the following scenarios.
1. sw=7'h41, press btn[0] -> one transfer addr 0 data 7'h41; cursor then (0,1).
2. Cursor at (0,59), write press -> transfer at addr 59; cursor (1,0). Cursor at (16,59), write press -> transfer at addr 1019; cursor (0,0).
3. Cursor (1,0), press btn[1] -> transfer addr 59 data 7'h20; cursor (0,59). Cursor at (0,0), press btn[1] -> transfer addr 0 data 7'h20; cursor stays (0,0).
4. Press btn[2] with wr_ready toggling 1/0 -> exactly 1020 transfers, addresses 0..1019 in order, all 7'h20; then busy=0 and cursor (0,0).
5. Assert btn[0] and btn[2] in the same cycle -> clear only. btn[0] glitch of 3 cycles -> no transfer. Press during CLEAR -> dropped.
6. Reset asserted at clear address 500 -> wr_valid=0 next cycle; no further transfers; state IDLE. en=0 for 10 cycles mid-clear -> no transfers, then resumes at the held address.

Source files
------------

// File: rtl/char_disp_pkg.sv
// Shared constants and types for the text cursor controller.
//   COLS/ROWS/CELLS : default screen geometry in character cells
//   SPACE           : blank character code written by backspace and clear
//   BTN_*           : bit positions of the buttons on the btn bus
//   state_e         : controller FSM states
//   cell_addr()     : row*cols+col computed at 10 bits
package char_disp_pkg;

   localparam int COLS  = 60;
   localparam int ROWS  = 17;
   localparam int CELLS = COLS * ROWS;

   localparam logic [6:0] SPACE = 7'h20;

   localparam int BTN_WRITE = 0;
   localparam int BTN_BKSP  = 1;
   localparam int BTN_CLEAR = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_BKSP,
      ST_CLEAR
   } state_e;

   function automatic logic [9:0] cell_addr(input logic [4:0] row,
                                            input logic [5:0] col,
                                            input logic [9:0] cols);
      return ({5'b0, row} * cols) + {4'b0, col};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchronizer, debounce counter and
// one-cycle rising-edge pulse of the debounced level.
//   clk, reset : clock, synchronous active-high reset
//   btn_in     : raw asynchronous button level
//   press      : one-cycle pulse on a debounced 0->1 transition
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 90000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The counter only runs while the synchronized input disagrees with the
   // accepted level; the level flips on the DEBOUNCE_CYCLES-th such cycle.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      press_d = level_d & ~level_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/text_cursor_controller.sv
// Text cursor controller: turns debounced write/backspace/clear buttons into
// character-RAM write requests and tracks the cursor position.
//   clk, reset            : clock, synchronous active-high reset
//   en                    : function enable, 0 freezes the FSM and cursor
//   btn[2:0]              : raw buttons {clear, backspace, write}
//   sw[6:0]               : character code to write
//   wr_valid/wr_ready     : write request / grant handshake
//   wr_addr, wr_data      : cell address (row*COLS+col) and character code
//   cursor_col/cursor_row : current cursor position
//   busy                  : high whenever an operation is in progress
module text_cursor_controller
   import char_disp_pkg::*;
#(
   parameter int COLS            = char_disp_pkg::COLS,
   parameter int ROWS            = char_disp_pkg::ROWS,
   parameter int DEBOUNCE_CYCLES = 90000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic [2:0] btn,
   input  logic [6:0] sw,
   output logic       wr_valid,
   input  logic       wr_ready,
   output logic [9:0] wr_addr,
   output logic [6:0] wr_data,
   output logic [5:0] cursor_col,
   output logic [4:0] cursor_row,
   output logic       busy
);

   if (COLS * ROWS > 1024) begin : g_size_check
      $error("text_cursor_controller: COLS*ROWS exceeds 1024 cells");
   end

   localparam logic [5:0] LAST_COL  = 6'(COLS - 1);
   localparam logic [4:0] LAST_ROW  = 5'(ROWS - 1);
   localparam logic [9:0] LAST_ADDR = 10'(COLS * ROWS - 1);
   localparam logic [9:0] COLS_W    = 10'(COLS);

   logic [2:0] press;

   for (genvar i = 0; i < 3; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_btn_debounce (
         .clk   (clk),
         .reset (reset),
         .btn_in(btn[i]),
         .press (press[i])
      );
   end

   state_e     state_q, state_d;
   logic [5:0] col_q, col_d;
   logic [4:0] row_q, row_d;
   logic       wr_valid_q, wr_valid_d;
   logic [9:0] addr_q, addr_d;
   logic [6:0] data_q, data_d;
   logic       busy_q, busy_d;
   logic       xfer;

   // Everything is gated by en, so en=0 simply holds every register and
   // press pulses that arrive meanwhile are lost.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      row_d      = row_q;
      wr_valid_d = wr_valid_q;
      addr_d     = addr_q;
      data_d     = data_q;
      xfer       = en & wr_valid_q & wr_ready;

      if (en) begin
         unique case (state_q)
            ST_IDLE: begin
               if (press[BTN_CLEAR]) begin
                  state_d    = ST_CLEAR;
                  addr_d     = '0;
                  data_d     = SPACE;
                  wr_valid_d = 1'b1;
               end else if (press[BTN_BKSP]) begin
                  if (col_q != '0) begin
                     col_d = col_q - 1'b1;
                  end else if (row_q != '0) begin
                     col_d = LAST_COL;
                     row_d = row_q - 1'b1;
                  end
                  addr_d     = cell_addr(row_d, col_d, COLS_W);
                  data_d     = SPACE;
                  wr_valid_d = 1'b1;
                  state_d    = ST_BKSP;
               end else if (press[BTN_WRITE]) begin
                  addr_d     = cell_addr(row_q, col_q, COLS_W);
                  data_d     = sw;
                  wr_valid_d = 1'b1;
                  state_d    = ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (xfer) begin
                  wr_valid_d = 1'b0;
                  state_d    = ST_IDLE;
                  if (col_q != LAST_COL) begin
                     col_d = col_q + 1'b1;
                  end else if (row_q != LAST_ROW) begin
                     col_d = '0;
                     row_d = row_q + 1'b1;
                  end else begin
                     col_d = '0;
                     row_d = '0;
                  end
               end
            end
            ST_BKSP: begin
               if (xfer) begin
                  wr_valid_d = 1'b0;
                  state_d    = ST_IDLE;
               end
            end
            ST_CLEAR: begin
               if (xfer) begin
                  if (addr_q == LAST_ADDR) begin
                     wr_valid_d = 1'b0;
                     col_d      = '0;
                     row_d      = '0;
                     state_d    = ST_IDLE;
                  end else begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         col_q      <= '0;
         row_q      <= '0;
         wr_valid_q <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         wr_valid_q <= wr_valid_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         busy_q     <= busy_d;
      end
   end

   assign wr_valid   = wr_valid_q & en;
   assign wr_addr    = addr_q;
   assign wr_data    = data_q;
   assign cursor_col = col_q;
   assign cursor_row = row_q;
   assign busy       = busy_q;

endmodule
